// File: rtl/tug_round_ctrl.sv
// -----------------------------------------------------------------------------
// tug_round_ctrl
//
// Round sequencer and referee for the tug-of-war game. It takes the
// single-cycle push pulses from both players and runs each round:
//   COUNT -> ARMED -> HOLD -> (COUNT | OVER)
// A push during COUNT is a false start. The first push while ARMED wins the
// point. The rope position moves one step per award. The match ends when the
// rope sits at either end after the result hold.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous, active-high reset
//   start               pulse: begin a match (accepted in IDLE or OVER)
//   push_l / push_r     pulse: left / right player push
//   armed               "go" light, high while the round is armed
//   pos                 signed rope position (negative = left winning)
//   pt_l / pt_r         pulse: round point to left / right player
//   foul_l / foul_r     pulse: false start by left / right player
//   tie                 pulse: simultaneous push while armed
//   winner_l / winner_r level: match winner, held until the next start
//   busy                high while a match is in progress (COUNT/ARMED/HOLD)
//
// All outputs are registered and reflect the decision taken on the previous
// clock edge.
// -----------------------------------------------------------------------------
module tug_round_ctrl #(
  parameter int CNT_W         = 16,
  parameter int COUNTDOWN_CYC = 1000,
  parameter int RESULT_CYC    = 500,
  parameter int POS_MAX       = 4,
  parameter int POS_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             push_l,
  input  logic             push_r,
  output logic             armed,
  output logic [POS_W-1:0] pos,
  output logic             pt_l,
  output logic             pt_r,
  output logic             foul_l,
  output logic             foul_r,
  output logic             tie,
  output logic             winner_l,
  output logic             winner_r,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_ARMED = 3'd2,
    S_HOLD  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]        CNT_CD   = CNT_W'(COUNTDOWN_CYC - 1);
  localparam logic [CNT_W-1:0]        CNT_RES  = CNT_W'(RESULT_CYC - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic signed [POS_W-1:0] POS_HI   = POS_W'(POS_MAX);
  localparam logic signed [POS_W-1:0] POS_LO   = -POS_HI;
  localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    armed_q, armed_d;
  logic                    busy_q, busy_d;
  logic                    pt_l_q, pt_l_d;
  logic                    pt_r_q, pt_r_d;
  logic                    foul_l_q, foul_l_d;
  logic                    foul_r_q, foul_r_d;
  logic                    tie_q, tie_d;
  logic                    winner_l_q, winner_l_d;
  logic                    winner_r_q, winner_r_d;

  // One-step rope moves, clamped at the ends. The award pulse fires even
  // when the clamp holds the rope in place.
  logic signed [POS_W-1:0] pos_up, pos_dn;
  assign pos_up = (pos_q == POS_HI) ? pos_q : pos_q + POS_ONE;
  assign pos_dn = (pos_q == POS_LO) ? pos_q : pos_q - POS_ONE;

  logic cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // State register (also holds every registered output)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pos_q      <= '0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      pt_l_q     <= 1'b0;
      pt_r_q     <= 1'b0;
      foul_l_q   <= 1'b0;
      foul_r_q   <= 1'b0;
      tie_q      <= 1'b0;
      winner_l_q <= 1'b0;
      winner_r_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      pt_l_q     <= pt_l_d;
      pt_r_q     <= pt_r_d;
      foul_l_q   <= foul_l_d;
      foul_r_q   <= foul_r_d;
      tie_q      <= tie_d;
      winner_l_q <= winner_l_d;
      winner_r_q <= winner_r_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and delay counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        // Pushes arriving with start are deliberately dropped here.
        if (start) begin
          state_d = S_COUNT;
          cnt_d   = CNT_CD;
        end
      end
      S_COUNT: begin
        // A push on the last countdown cycle is still a false start.
        if (push_l || push_r) begin
          state_d = S_HOLD;
          cnt_d   = CNT_RES;
        end else if (cnt_zero) begin
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ARMED: begin
        if (push_l || push_r) begin
          state_d = S_HOLD;
          cnt_d   = CNT_RES;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          if ((pos_q == POS_LO) || (pos_q == POS_HI)) begin
            state_d = S_OVER;
          end else begin
            state_d = S_COUNT;
            cnt_d   = CNT_CD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    pos_d      = pos_q;
    pt_l_d     = 1'b0;
    pt_r_d     = 1'b0;
    foul_l_d   = 1'b0;
    foul_r_d   = 1'b0;
    tie_d      = 1'b0;
    winner_l_d = winner_l_q;
    winner_r_d = winner_r_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          pos_d      = '0;
          winner_l_d = 1'b0;
          winner_r_d = 1'b0;
        end
      end
      S_COUNT: begin
        // A false start hands the step to the opponent.
        if (push_l && push_r) begin
          foul_l_d = 1'b1;
          foul_r_d = 1'b1;
        end else if (push_l) begin
          foul_l_d = 1'b1;
          pos_d    = pos_up;
        end else if (push_r) begin
          foul_r_d = 1'b1;
          pos_d    = pos_dn;
        end
      end
      S_ARMED: begin
        if (push_l && push_r) begin
          tie_d = 1'b1;
        end else if (push_l) begin
          pt_l_d = 1'b1;
          pos_d  = pos_dn;
        end else if (push_r) begin
          pt_r_d = 1'b1;
          pos_d  = pos_up;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          if (pos_q == POS_LO) begin
            winner_l_d = 1'b1;
          end else if (pos_q == POS_HI) begin
            winner_r_d = 1'b1;
          end
        end
      end
      default: begin
        pos_d      = '0;
        winner_l_d = 1'b0;
        winner_r_d = 1'b0;
      end
    endcase
    armed_d = (state_d == S_ARMED);
    busy_d  = (state_d == S_COUNT) || (state_d == S_ARMED) || (state_d == S_HOLD);
  end

  assign armed    = armed_q;
  assign pos      = pos_q;
  assign pt_l     = pt_l_q;
  assign pt_r     = pt_r_q;
  assign foul_l   = foul_l_q;
  assign foul_r   = foul_r_q;
  assign tie      = tie_q;
  assign winner_l = winner_l_q;
  assign winner_r = winner_r_q;
  assign busy     = busy_q;

endmodule
